ram16x256_dp: RTL and testbench
===============================

# ram16x256_dp

Simple dual-port synchronous RAM, 256 words × 16 bits, with one write port and one read port on a single clock. It is the sample delay-line store behind the decimating FIR low-pass filters of the FM stereo demodulator. The filter writes one input sample per `ast_sink_valid` and reads taps back at any address every clock.

## Interface

Parameters:
- `DATA_WIDTH`, default 16: word width.
- `ADDR_WIDTH`, default 8: address width. Depth is 2^ADDR_WIDTH, which is 256.

Ports:
- `clk`, input, 1: clock. All activity is on the rising edge.
- `reset_n`, input, 1: reset, synchronous, active-low; clock `clk`.
- `data`, input, DATA_WIDTH: write data, signed sample bits stored verbatim.
- `wraddress`, input, ADDR_WIDTH: write address.
- `wren`, input, 1: write enable.
- `rdaddress`, input, ADDR_WIDTH: read address, sampled every clock.
- `q`, output, DATA_WIDTH: registered read data.
- `busy`, output, 1: high while the block is in reset or in the clear sweep. It is tied to 0 when `RAM16X256_CLEAR_ON_RESET_EN` is undefined.

## Operation

- Storage is `mem[0..255]` of DATA_WIDTH bits. The simulation power-up content is all zeros.
- Write: on a rising edge with `reset_n`=1, `wren`=1 and `busy`=0, `mem[wraddress] <= data`.
- Read: on every rising edge with `reset_n`=1 and `busy`=0, `q <= mem[rdaddress]`. There is no read enable.
- Read-during-write at the same address returns the OLD word. The new word is visible from the next read onward.
- Writes and reads at different addresses are fully independent in the same cycle.
- Addresses are full range (0–255) with no checking. The caller performs any modulo-256 wrap, for example a ring buffer with `wraddress` going 255→0.
- Data is opaque. There is no sign extension or arithmetic.
- Reset (`reset_n`=0 at an edge):
  - `q <= 0`.
  - Writes are inhibited.
  - Memory contents are retained unless the clear feature is compiled in.

## Timing

- Read latency is 1 clock. An address presented before edge k gives `q` valid after edge k, held until edge k+1.
- Write latency is 1 clock. Data written at edge k is readable by an address presented for edge k+1, with `q` valid after k+1.
- Throughput is one write plus one read every clock, with no stalls.
- `q` is 0 from the first reset edge until the first read edge after reset is released (and after the clear sweep, if compiled in).
- `reset_n` asserted mid-operation: at that edge `q` goes to 0 and any write presented in that cycle is dropped.

## Configuration

- Macro `RAM16X256_CLEAR_ON_RESET_EN`.
- Defined:
  - During reset, `busy`=1 and the clear pointer is set to 0.
  - After `reset_n` rises, a 256-cycle sweep writes 0 to `mem[0..255]`, one word per clock in ascending order.
  - During the sweep, `busy`=1, user writes are ignored, and `q` holds 0.
  - `busy` drops after the write to address 255, so normal operation starts 256 clocks after release.
  - Reset asserted during the sweep restarts it from address 0.
- Undefined:
  - No sweep takes place and `busy` is constant 0.
  - The first write and read are accepted on the first edge after `reset_n` rises.
  - Contents survive reset.

## Test plan

- Basic write/read: write 16'h1234 @5, then read @5 on the next cycle; `q`=16'h1234 one clock after the address.
- Read-during-write: `mem[7]`=16'hAAAA; same edge write 16'h5555 @7 and read @7. `q`=16'hAAAA; re-reading @7 on the following cycle gives `q`=16'h5555.
- Wrap and full range: write `data`=addr+1 to addresses 0..255 with `wraddress` wrapping 255→0, then overwrite @0 with 16'hFFFF. Read 254, 255, 0, 1 back-to-back; `q` must be 255, 256, 16'hFFFF, 2 on consecutive clocks.
- Streaming: write and read different addresses every cycle for 1000 cycles against a reference model; read latency must be exactly 1 with zero mismatches.
- Reset mid-stream: hold `reset_n`=0 for 1 cycle while `wren`=1 @9 with 16'hBEEF.
  - `q`=0 after that edge and `mem[9]` is unchanged.
  - Without the macro, prior contents are intact.
  - With `RAM16X256_CLEAR_ON_RESET_EN`, `busy` stays high for 256 clocks after release and all reads return 0 afterwards.
- Signed data: write 16'h8000 and 16'h7FFF; both read back bit-exact.

Source files
------------

// File: rtl/ram16x256_dp.sv
// ----------------------------------------------------------------------------
// ram16x256_dp
//
// Simple dual-port synchronous RAM used as the sample delay-line store of the
// decimating FIR low-pass filters in the FM stereo demodulator. The block has
// one write port and one read port on a single clock. The filter writes one
// sample per input beat and reads taps back at any address on every clock.
//
// Reads return the OLD word when the same address is written on the same
// edge. Read latency is one clock and write latency is one clock.
//
// Optional feature (compile-time macro):
//   RAM16X256_CLEAR_ON_RESET_EN - after reset_n rises, zero all words with a
//                                 one-word-per-clock sweep in ascending order.
//                                 busy is high during reset and the sweep.
//                                 When the macro is undefined, busy is tied to
//                                 0 and the contents survive reset.
//
// Ports:
//   clk        in   1           rising-edge clock
//   reset_n    in   1           synchronous active-low reset
//   data       in   DATA_WIDTH  write data, stored verbatim
//   wraddress  in   ADDR_WIDTH  write address
//   wren       in   1           write enable
//   rdaddress  in   ADDR_WIDTH  read address, sampled every clock
//   q          out  DATA_WIDTH  registered read data
//   busy       out  1           high during reset or the clear sweep
// ----------------------------------------------------------------------------
module ram16x256_dp #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [ADDR_WIDTH-1:0] wraddress,
   input  logic                  wren,
   input  logic [ADDR_WIDTH-1:0] rdaddress,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  busy
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // The write request that reaches the array after the clear sweep has been
   // merged in.
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_wa;
   logic [DATA_WIDTH-1:0] mem_wd;
   logic                  busy_int;

`ifdef RAM16X256_CLEAR_ON_RESET_EN
   logic [ADDR_WIDTH-1:0] clr_ptr;
   logic                  clearing;

   // Reset parks the pointer at 0 and keeps the sweep armed. The sweep runs
   // once reset_n rises and ends after the write to the last address, so a
   // reset during the sweep restarts it from address 0.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         clearing <= 1'b1;
         clr_ptr  <= '0;
      end else if (clearing) begin
         clr_ptr <= clr_ptr + 1'b1;
         if (clr_ptr == '1) begin
            clearing <= 1'b0;
         end
      end
   end

   assign busy_int = clearing;

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      mem_we = wren;
      mem_wa = wraddress;
      mem_wd = data;
      if (clearing) begin
         mem_we = 1'b1;
         mem_wa = clr_ptr;
         mem_wd = '0;
      end
   end
`else
   assign busy_int = 1'b0;

   always_comb begin
      mem_we = wren;
      mem_wa = wraddress;
      mem_wd = data;
   end
`endif

   assign busy = busy_int;

   // NOTE: the array has no reset branch; a reset on every word would block
   // mapping onto block RAM. Clearing, when wanted, is the sweep above.
   always_ff @(posedge clk) begin
      if (reset_n && mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   // NOTE: non-blocking assignments mean this read sees the array as it was
   // before the edge, which gives the old-word behaviour on a same-address
   // read-during-write.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q <= '0;
      end else if (busy_int) begin
         q <= '0;
      end else begin
         q <= mem[rdaddress];
      end
   end

endmodule

// File: tb/tb_ram16x256_dp.sv
// ----------------------------------------------------------------------------
// tb_ram16x256_dp
//
// Self-checking bench for ram16x256_dp. A reference array tracks the RAM.
// Every driven cycle pushes the expected q to a scoreboard queue, and the
// entry is popped and compared just after the following rising edge. The
// scenario tasks also compare q against literal values.
// ----------------------------------------------------------------------------
module tb_ram16x256_dp;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] data;
   logic [7:0]  wraddress;
   logic        wren;
   logic [7:0]  rdaddress;
   logic [15:0] q;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] model [256];
   logic [15:0] sb_q [$];

   ram16x256_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .data      (data),
      .wraddress (wraddress),
      .wren      (wren),
      .rdaddress (rdaddress),
      .q         (q),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // One clock of stimulus. The expected q is computed from the model before
   // the model takes this cycle's write, which gives old-word read-during-write.
   task automatic step(input logic rst, input logic we, input logic [7:0] wa,
                       input logic [15:0] wd, input logic [7:0] ra,
                       input string tag);
      logic [15:0] exp_q;
      exp_q = rst ? model[ra] : 16'h0000;
      sb_q.push_back(exp_q);
      if (rst && we) model[wa] = wd;
      reset_n   = rst;
      wren      = we;
      wraddress = wa;
      data      = wd;
      rdaddress = ra;
      @(posedge clk);
      #1;
      exp_q = sb_q.pop_front();
      vectors++;
      if (q !== exp_q) begin
         miscompares++;
         $display("FAIL %s: q=%h expected %h", tag, q, exp_q);
      end
   endtask

   // Releases reset and follows the clear sweep when it is compiled in. The
   // user write presented during the sweep must be ignored.
   task automatic wait_sweep(input string tag);
`ifdef RAM16X256_CLEAR_ON_RESET_EN
      int cnt;
      reset_n   = 1'b1;
      wren      = 1'b1;
      wraddress = 8'd3;
      data      = 16'hDEAD;
      rdaddress = 8'd3;
      cnt       = 0;
      do begin
         @(posedge clk);
         #1;
         cnt++;
         vectors++;
         if (q !== 16'h0000) begin
            miscompares++;
            $display("FAIL %s_q_during_sweep: q=%h expected 0000", tag, q);
         end
      end while (busy && cnt < 300);
      vectors++;
      if (cnt != 256) begin
         miscompares++;
         $display("FAIL %s_sweep_len: busy cycles=%0d expected 256", tag, cnt);
      end
      wren = 1'b0;
      for (int i = 0; i < 256; i++) model[i] = 16'h0000;
`else
      reset_n = 1'b1;
`endif
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      wren      = 1'b0;
      wraddress = '0;
      data      = '0;
      rdaddress = '0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (q !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_q: q=%h expected 0000", q);
         end
         vectors++;
`ifdef RAM16X256_CLEAR_ON_RESET_EN
         if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy: busy=%b expected 1", busy);
         end
`else
         if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: busy=%b expected 0", busy);
         end
`endif
      end
      wait_sweep("reset");
   endtask

   task automatic test_basic();
      step(1'b1, 1'b1, 8'd5, 16'h1234, 8'd6, "basic_wr");
      step(1'b1, 1'b0, 8'd0, 16'h0000, 8'd5, "basic_rd");
      vectors++;
      if (q !== 16'h1234) begin
         miscompares++;
         $display("FAIL basic_value: q=%h expected 1234", q);
      end
   endtask

   task automatic test_rdw();
      step(1'b1, 1'b1, 8'd7, 16'hAAAA, 8'd5, "rdw_init");
      step(1'b1, 1'b1, 8'd7, 16'h5555, 8'd7, "rdw_same");
      vectors++;
      if (q !== 16'hAAAA) begin
         miscompares++;
         $display("FAIL rdw_old: q=%h expected aaaa", q);
      end
      step(1'b1, 1'b0, 8'd0, 16'h0000, 8'd7, "rdw_next");
      vectors++;
      if (q !== 16'h5555) begin
         miscompares++;
         $display("FAIL rdw_new: q=%h expected 5555", q);
      end
   endtask

   task automatic test_wrap();
      logic [15:0] want [4];
      logic [7:0]  addr [4];
      logic [8:0]  ctr;
      want = '{16'd255, 16'd256, 16'hFFFF, 16'd2};
      addr = '{8'd254, 8'd255, 8'd0, 8'd1};
      ctr  = '0;
      for (int i = 0; i <= 256; i++) begin
         step(1'b1, 1'b1, ctr[7:0], (i == 256) ? 16'hFFFF : 16'(i + 1),
              8'd5, "wrap_fill");
         ctr = ctr + 9'd1;
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 8'd0, 16'h0000, addr[i], "wrap_rd");
         vectors++;
         if (q !== want[i]) begin
            miscompares++;
            $display("FAIL wrap_value@%0d: q=%h expected %h", addr[i], q, want[i]);
         end
      end
   endtask

   task automatic test_signed();
      step(1'b1, 1'b1, 8'd20, 16'h8000, 8'd0, "sgn_wr0");
      step(1'b1, 1'b1, 8'd21, 16'h7FFF, 8'd20, "sgn_wr1");
      vectors++;
      if (q !== 16'h8000) begin
         miscompares++;
         $display("FAIL signed_8000: q=%h expected 8000", q);
      end
      step(1'b1, 1'b0, 8'd0, 16'h0000, 8'd21, "sgn_rd");
      vectors++;
      if (q !== 16'h7FFF) begin
         miscompares++;
         $display("FAIL signed_7fff: q=%h expected 7fff", q);
      end
   endtask

   task automatic test_stream();
      logic [7:0]  wa;
      logic [7:0]  ra;
      logic [15:0] wd;
      wa = 8'd100;
      for (int i = 0; i < 1000; i++) begin
         wd = 16'($urandom);
         ra = 8'($urandom);
         if (ra == wa) ra = ra + 8'd1;
         step(1'b1, 1'b1, wa, wd, ra, "stream");
         wa = wa + 8'd1;
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] old9;
      old9 = model[9];
      step(1'b0, 1'b1, 8'd9, 16'hBEEF, 8'd9, "rstmid_q");
      vectors++;
      if (q !== 16'h0000) begin
         miscompares++;
         $display("FAIL rstmid_q_zero: q=%h expected 0000", q);
      end
      wait_sweep("rstmid");
      step(1'b1, 1'b0, 8'd0, 16'h0000, 8'd9, "rstmid_rd9");
      vectors++;
`ifdef RAM16X256_CLEAR_ON_RESET_EN
      if (q !== 16'h0000) begin
         miscompares++;
         $display("FAIL rstmid_cleared: q=%h expected 0000", q);
      end
      step(1'b1, 1'b0, 8'd0, 16'h0000, 8'd3, "rstmid_rd3");
      step(1'b1, 1'b0, 8'd0, 16'h0000, 8'd255, "rstmid_rd255");
`else
      if (q !== old9) begin
         miscompares++;
         $display("FAIL rstmid_kept: q=%h expected %h", q, old9);
      end
      step(1'b1, 1'b0, 8'd0, 16'h0000, 8'd21, "rstmid_rd21");
      step(1'b1, 1'b0, 8'd0, 16'h0000, 8'd7, "rstmid_rd7");
`endif
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_busy: busy=%b expected 0", busy);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) model[i] = 16'h0000;
      test_reset();
      test_basic();
      test_rdw();
      test_wrap();
      test_signed();
      test_stream();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
